// File: rtl/dvs_ravens_stream_transmitter.sv
// Buffered DVS-to-RAVENS transmitter. It queues timestamped spikes, groups them into
// RAVENS timesteps and sim times, and emits START/RUN/SPIKE packets over valid/ready.
module dvs_ravens_stream_transmitter #(
    parameter int SEGMENT_LENGTH_US         = 25,
    parameter int NUM_SEGMENTS_PER_SIM_TIME = 10,
    parameter int SIM_TIME                  = 15,
    parameter int TS_BITS                   = 32,
    parameter int PKT_BITS                  = 32,
    parameter int FIFO_DEPTH                = 8,
    parameter int DROP_CNT_BITS             = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [TS_BITS-1:0]       in_timestamp_us,
    input  logic [PKT_BITS-1:0]      in_spike,
    input  logic [TS_BITS-1:0]       time_us,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [PKT_BITS-1:0]      out_pkt,
    output logic [DROP_CNT_BITS-1:0] dropped_count,
    output logic                     sim_time_active
);

    localparam int CNT_BITS  = $clog2(SIM_TIME + 1);
    localparam int ADDR_BITS = $clog2(FIFO_DEPTH);
    localparam int ENTRY_BITS = TS_BITS + PKT_BITS;

    localparam logic [TS_BITS-1:0]   SEG_LEN   = TS_BITS'(SEGMENT_LENGTH_US);
    localparam logic [TS_BITS-1:0]   STALE_WIN = TS_BITS'(SEGMENT_LENGTH_US * NUM_SEGMENTS_PER_SIM_TIME);
    localparam logic [TS_BITS:0]     NUM_SEGS  = (TS_BITS + 1)'(NUM_SEGMENTS_PER_SIM_TIME);
    localparam logic [CNT_BITS-1:0]  SIM_STEPS = CNT_BITS'(SIM_TIME);
    localparam logic [ADDR_BITS:0]   DEPTH_CNT = (ADDR_BITS + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_WAIT_NEW,
        S_WAIT_IN,
        S_START,
        S_RUN,
        S_SEND
    } state_t;

    state_t state, next_state;

    // ---------------------------------------------------------------- input FIFO
    logic [ENTRY_BITS-1:0] mem [FIFO_DEPTH];
    logic [ADDR_BITS-1:0]  wr_ptr, rd_ptr;
    logic [ADDR_BITS:0]    fifo_count;
    logic                  fifo_empty;
    logic                  push, pop;
    logic [TS_BITS-1:0]    head_ts;
    logic [PKT_BITS-1:0]   head_spike;

    assign in_ready   = (fifo_count != DEPTH_CNT);
    assign fifo_empty = (fifo_count == '0);
    assign push       = in_valid && in_ready;
    assign head_ts    = mem[rd_ptr][ENTRY_BITS-1 -: TS_BITS];
    assign head_spike = mem[rd_ptr][PKT_BITS-1:0];

    // NOTE: storage has no reset; the pointers and count alone define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {in_timestamp_us, in_spike};
        end
    end

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // ---------------------------------------------------------------- timestep arithmetic
    logic [TS_BITS-1:0]  seg_last;
    logic [CNT_BITS-1:0] step;
    logic [TS_BITS-1:0]  t_start;
    logic [CNT_BITS-1:0] run_n;
    logic                run_ends_sim;

    logic [TS_BITS-1:0]  delta;
    logic [TS_BITS-1:0]  n_raw;
    logic [TS_BITS:0]    step_sum;
    logic [CNT_BITS-1:0] run_n_calc;
    logic                ends_calc;
    logic                head_fresh;

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        delta      = head_ts - seg_last - 1'b1;
        n_raw      = '0;
        step_sum   = '0;
        run_n_calc = '0;
        ends_calc  = 1'b0;
        if (head_ts > seg_last) begin
            n_raw = delta / SEG_LEN + 1'b1;
        end
        step_sum = {1'b0, n_raw} + (TS_BITS + 1)'(step);
        if (step_sum >= NUM_SEGS) begin
            run_n_calc = SIM_STEPS - step;
            ends_calc  = 1'b1;
        end else begin
            run_n_calc = n_raw[CNT_BITS-1:0];
        end
    end

    // Spikes older than one full sim-time window behind the sim-time start are stale.
    assign head_fresh = (head_ts > t_start) || ((t_start - head_ts) < STALE_WIN);

    // ---------------------------------------------------------------- control FSM
    logic handshake;
    logic drop;
    logic load_run;

    assign handshake = out_valid && out_ready;

    always_comb begin
        next_state = state;
        pop        = 1'b0;
        drop       = 1'b0;
        load_run   = 1'b0;
        case (state)
            S_WAIT_NEW: begin
                if (!fifo_empty) begin
                    if (head_fresh) begin
                        next_state = S_START;
                    end else begin
                        pop  = 1'b1;
                        drop = 1'b1;
                    end
                end
            end
            S_WAIT_IN: begin
                if (!fifo_empty) begin
                    load_run   = 1'b1;
                    next_state = (run_n_calc != '0) ? S_RUN : S_SEND;
                end
            end
            S_START: begin
                if (handshake) next_state = S_SEND;
            end
            S_RUN: begin
                if (handshake) next_state = run_ends_sim ? S_WAIT_NEW : S_SEND;
            end
            S_SEND: begin
                if (handshake) begin
                    pop        = 1'b1;
                    next_state = S_WAIT_IN;
                end
            end
            default: next_state = S_WAIT_NEW;
        endcase
    end

    // Packet to present when entering an emit state.
    logic [PKT_BITS-1:0] next_pkt;
    logic                next_emits;

    always_comb begin
        next_pkt   = '0;
        next_emits = 1'b0;
        case (next_state)
            S_START: begin
                next_emits = 1'b1;
                next_pkt[PKT_BITS-1 -: 3] = 3'b010;
            end
            S_RUN: begin
                next_emits = 1'b1;
                next_pkt[PKT_BITS-1 -: 3] = 3'b001;
                next_pkt[CNT_BITS-1:0]    = run_n_calc;
            end
            S_SEND: begin
                next_emits = 1'b1;
                next_pkt   = head_spike;
            end
            default: begin
                next_emits = 1'b0;
                next_pkt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state           <= S_WAIT_NEW;
            seg_last        <= '0;
            step            <= '0;
            t_start         <= '0;
            run_n           <= '0;
            run_ends_sim    <= 1'b0;
            dropped_count   <= '0;
            sim_time_active <= 1'b0;
            out_valid       <= 1'b0;
            out_pkt         <= '0;
        end else begin
            state     <= next_state;
            out_valid <= next_emits;
            // out_pkt is only reloaded on entry, so it holds steady under backpressure.
            if (next_emits && (next_state != state)) begin
                out_pkt <= next_pkt;
            end

            if (load_run) begin
                run_n        <= run_n_calc;
                run_ends_sim <= ends_calc;
            end

            if (state == S_START && handshake) begin
                seg_last        <= head_ts;
                step            <= '0;
                sim_time_active <= 1'b1;
            end

            if (state == S_RUN && handshake) begin
                seg_last <= seg_last + TS_BITS'(run_n) * SEG_LEN;
                if (run_ends_sim) begin
                    step            <= '0;
                    sim_time_active <= 1'b0;
                end else begin
                    step <= step + run_n;
                end
            end

            if (next_state == S_WAIT_NEW && state != S_WAIT_NEW) begin
                t_start <= time_us;
            end

            if (drop && (dropped_count != {DROP_CNT_BITS{1'b1}})) begin
                dropped_count <= dropped_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dvs_ravens_stream_transmitter.sv
// Directed bench for dvs_ravens_stream_transmitter: stimulus queues expected packets,
// an independent monitor compares every accepted output packet in order.
module tb_dvs_ravens_stream_transmitter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_timestamp_us;
    logic [31:0] in_spike;
    logic [31:0] time_us;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pkt;
    logic [15:0] dropped_count;
    logic        sim_time_active;

    int vectors     = 0;
    int miscompares = 0;
    logic [31:0] exp_q [$];

    always #5 clk = ~clk;

    dvs_ravens_stream_transmitter dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_timestamp_us (in_timestamp_us),
        .in_spike        (in_spike),
        .time_us         (time_us),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_pkt         (out_pkt),
        .dropped_count   (dropped_count),
        .sim_time_active (sim_time_active)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: a packet is consumed at the edge following a valid&&ready sample.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_pkt: got %0h expected none", out_pkt);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                if (out_pkt !== e) begin
                    miscompares++;
                    $display("FAIL out_pkt: got %0h expected %0h", out_pkt, e);
                end
            end
        end
    end

    task automatic expect_pkt(input logic [31:0] p);
        exp_q.push_back(p);
    endtask

    task automatic push(input logic [31:0] ts, input logic [31:0] spk);
        int n = 0;
        while (!in_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) begin
            check("push_ready_timeout", {31'b0, in_ready}, 32'd1);
        end else begin
            in_valid        = 1'b1;
            in_timestamp_us = ts;
            in_spike        = spk;
            @(posedge clk); #1;
            in_valid = 1'b0;
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        check("drain_remaining", exp_q.size(), 32'd0);
        repeat (4) @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n           = 1'b0;
        in_valid        = 1'b0;
        in_timestamp_us = '0;
        in_spike        = '0;
        time_us         = '0;
        out_ready       = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_out_pkt", out_pkt, 32'd0);
        check("rst_in_ready", {31'b0, in_ready}, 32'd1);
        check("rst_dropped", {16'b0, dropped_count}, 32'd0);
        check("rst_sim_active", {31'b0, sim_time_active}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 1: first spike opens a sim time
        expect_pkt(32'h4000_0000);
        expect_pkt(32'hA500_0001);
        push(32'd1000, 32'hA500_0001);
        wait_idle();
        check("t1_sim_active", {31'b0, sim_time_active}, 32'd1);

        // 2: three timesteps advance, then a spike in the current timestep
        expect_pkt(32'h2000_0003);
        expect_pkt(32'hA500_0002);
        push(32'd1060, 32'hA500_0002);
        wait_idle();
        expect_pkt(32'hA500_0003);
        push(32'd1075, 32'hA500_0003);
        wait_idle();

        // 3: far spike closes the sim time with the remaining 12 steps, then restarts
        time_us = 32'd1400;
        expect_pkt(32'h2000_000C);
        expect_pkt(32'h4000_0000);
        expect_pkt(32'hA500_0004);
        push(32'd1400, 32'hA500_0004);
        wait_idle();
        check("t3_sim_active", {31'b0, sim_time_active}, 32'd1);

        // 4: closing RUN of 15, t_start=5000, ts=4700 is stale and dropped
        time_us = 32'd5000;
        expect_pkt(32'h2000_000F);
        push(32'd4700, 32'hA500_0005);
        wait_idle();
        check("t4_dropped", {16'b0, dropped_count}, 32'd1);
        check("t4_sim_idle", {31'b0, sim_time_active}, 32'd0);
        expect_pkt(32'h4000_0000);
        expect_pkt(32'hA500_0006);
        push(32'd4800, 32'hA500_0006);
        wait_idle();
        check("t4_dropped_hold", {16'b0, dropped_count}, 32'd1);

        // 5: backpressure during RUN while the FIFO fills
        out_ready = 1'b0;
        expect_pkt(32'h2000_0004);
        for (int i = 0; i < 8; i++) expect_pkt(32'hB000_0000 + 32'(i));
        for (int i = 0; i < 8; i++) push(32'd4900, 32'hB000_0000 + 32'(i));
        check("t5_full_ready", {31'b0, in_ready}, 32'd0);
        in_valid        = 1'b1;
        in_timestamp_us = 32'd4900;
        in_spike        = 32'hBEEF_0009;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            check("t5_stall_valid", {31'b0, out_valid}, 32'd1);
            check("t5_stall_pkt", out_pkt, 32'h2000_0004);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        wait_idle();
        check("t5_ready_after", {31'b0, in_ready}, 32'd1);

        // 6: reset while SEND is pending with 4 entries buffered
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) push(32'd4900, 32'hC000_0000 + 32'(i));
        begin
            int n = 0;
            while (!out_valid && n < 50) begin
                @(posedge clk); #1;
                n++;
            end
        end
        check("t6_pending_pkt", out_pkt, 32'hC000_0000);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("t6_rst_valid", {31'b0, out_valid}, 32'd0);
        check("t6_rst_ready", {31'b0, in_ready}, 32'd1);
        check("t6_rst_dropped", {16'b0, dropped_count}, 32'd0);
        check("t6_rst_active", {31'b0, sim_time_active}, 32'd0);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        time_us   = 32'd0;
        @(posedge clk); #1;
        expect_pkt(32'h4000_0000);
        expect_pkt(32'hD000_0001);
        push(32'd100, 32'hD000_0001);
        wait_idle();
        check("t6_sim_active", {31'b0, sim_time_active}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
